// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative shift-add multiplier with register-file write-back
module mul_unit #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic               hi_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [REGBITS-1:0] dst,
  output logic               busy,
  output logic               done,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, WR_LO, WR_HI} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        count_q, count_d;
  logic [REGBITS-1:0]   dst_q, dst_d;
  logic                 hi_en_q, hi_en_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 regwrite_q, regwrite_d;
  logic [REGBITS-1:0]   wa_q, wa_d;
  logic [WIDTH-1:0]     wd_q, wd_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   sum, result;

  // Next-state, datapath step and registered write-port values
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    count_d    = count_q;
    dst_d      = dst_q;
    hi_en_d    = hi_en_q;
    neg_d      = neg_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    regwrite_d = 1'b0;
    wa_d       = '0;
    wd_d       = '0;

    // Magnitudes: the most negative value maps onto itself, which is correct
    // once read as an unsigned WIDTH-bit number.
    mag_a = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    sum    = prod_q + (mplier_q[0] ? mcand_q : '0);
    result = neg_q ? (~sum + (2*WIDTH)'(1)) : sum;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          prod_d   = '0;
          count_d  = '0;
          dst_d    = dst;
          hi_en_d  = hi_en;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        prod_d   = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Last step folds the sign fix-up in so the low word is ready for WR_LO.
        if (count_q == CW'(WIDTH - 1)) begin
          prod_d     = result;
          state_d    = WR_LO;
          regwrite_d = 1'b1;
          wa_d       = dst_q;
          wd_d       = result[WIDTH-1:0];
          done_d     = ~hi_en_q;
        end
      end
      WR_LO: begin
        if (hi_en_q) begin
          state_d    = WR_HI;
          busy_d     = 1'b1;
          regwrite_d = 1'b1;
          wa_d       = dst_q + REGBITS'(1);
          wd_d       = prod_q[2*WIDTH-1:WIDTH];
          done_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR_HI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      count_q    <= '0;
      dst_q      <= '0;
      hi_en_q    <= 1'b0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      count_q    <= count_d;
      dst_q      <= dst_d;
      hi_en_q    <= hi_en_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign regwrite = regwrite_q;
  assign wa       = wa_q;
  assign wd       = wd_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - self-checking bench for mul_unit with a write scoreboard
module tb_mul_unit;
  localparam int W  = 16;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          reset, start, signed_op, hi_en;
  logic [W-1:0]  a, b;
  logic [RB-1:0] dst;
  logic          busy, done, regwrite;
  logic [RB-1:0] wa;
  logic [W-1:0]  wd;

  typedef struct packed {
    logic [RB-1:0] wa;
    logic [W-1:0]  wd;
    logic          done;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  fails  = 0;

  mul_unit #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .hi_en(hi_en),
    .a(a), .b(b), .dst(dst), .busy(busy), .done(done), .regwrite(regwrite),
    .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [W-1:0] ea, input logic [W-1:0] eb,
                               input logic s, input logic h, input logic [RB-1:0] d);
    logic [31:0]   p;
    logic [RB-1:0] d1;
    if (s) p = {{16{ea[15]}}, ea} * {{16{eb[15]}}, eb};
    else   p = {16'b0, ea} * {16'b0, eb};
    exp_q.push_back('{wa: d, wd: p[15:0], done: ~h});
    if (h) begin
      d1 = d + 4'd1;
      exp_q.push_back('{wa: d1, wd: p[31:16], done: 1'b1});
    end
  endtask

  // Called just after a falling edge; watches n cycles for any write-port activity.
  task automatic quiet(input string tag, input int n);
    int act = 0;
    for (int k = 0; k < n; k++) begin
      if (regwrite || done || busy) act++;
      @(negedge clk);
    end
    check(tag, act, 0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic s, input logic h, input logic [RB-1:0] d,
                        input int pulse_at, input int reset_at);
    wr_t e;
    int  busy_cnt = 0;
    int  first_wr = 0;
    bit  got_done = 0;
    push_expected(oa, ob, s, h, d);
    start = 1'b1; a = oa; b = ob; signed_op = s; hi_en = h; dst = d;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); dst = RB'($urandom);
    signed_op = 1'($urandom); hi_en = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (regwrite) begin
        if (first_wr == 0) first_wr = k;
        if (exp_q.size() == 0) check({tag, "_extra_write"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          check({tag, "_wa"}, 32'(wa), 32'(e.wa));
          check({tag, "_wd"}, 32'(wd), 32'(e.wd));
          check({tag, "_done"}, 32'(done), 32'(e.done));
        end
      end else if (done) begin
        check({tag, "_done_no_write"}, 1, 0);
      end
      if (done) begin
        got_done = 1;
        start = (k == pulse_at);
        if (k == pulse_at) begin a = 16'd7; b = 16'd7; end
        @(negedge clk);
        start = 1'b0;
        break;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_regwrite"}, 32'(regwrite), 0);
        exp_q.delete();
        quiet({tag, "_rst_quiet"}, 14);
        return;
      end
      start = (k == pulse_at);
      if (k == pulse_at) begin a = 16'd7; b = 16'd7; end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got_done), 1);
    check({tag, "_latency"}, first_wr, 17);
    check({tag, "_busy_cycles"}, busy_cnt, h ? 18 : 17);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; hi_en = 1'b0;
    a = '0; b = '0; dst = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_regwrite", 32'(regwrite), 0);
    check("reset_wa", 32'(wa), 0);
    check("reset_wd", 32'(wd), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op("unsigned_3x5", 16'd3, 16'd5, 1'b0, 1'b0, 4'd2, 0, 0);
    run_op("signed_m2x3", 16'hFFFE, 16'h0003, 1'b1, 1'b1, 4'd4, 0, 0);
    run_op("max_wrap", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 4'd15, 0, 0);
    run_op("signed_extreme", 16'h8000, 16'h8000, 1'b1, 1'b1, 4'd6, 0, 0);
    run_op("signed_pos_neg", 16'd1234, 16'hFF85, 1'b1, 1'b0, 4'd9, 0, 0);
    run_op("busy_start", 16'd3, 16'd5, 1'b0, 1'b0, 4'd2, 5, 0);
    quiet("busy_start_quiet", 25);
    run_op("done_start", 16'd11, 16'd13, 1'b0, 1'b0, 4'd3, 17, 0);
    quiet("done_start_quiet", 25);
    run_op("reset_mid", 16'd3, 16'd5, 1'b0, 1'b0, 4'd2, 0, 8);
    run_op("after_reset", 16'd2, 16'd4, 1'b0, 1'b0, 4'd1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
